// File: rtl/wb_pkg.sv
// Shared types for the write-back/commit stage: packet layout, result selects and FSM states.
// Packet fields are sized for the widest configuration; narrower instances use the low bits.
package wb_pkg;

    localparam int WB_DATA_MAX = 64;
    localparam int WB_RD_MAX   = 8;

    typedef enum logic [3:0] {
        ALU, BR_EN, U_IMM, PC4, LB, LBU, LH, LHU, LW, LWU, LD
    } wb_sel_e;

    typedef enum logic [1:0] {
        EMPTY, HELD, DRAIN
    } wb_state_e;

    typedef struct packed {
        logic [WB_RD_MAX-1:0]   rd;
        logic                   load_regfile;
        wb_sel_e                sel;
        logic [WB_DATA_MAX-1:0] alu_out;
        logic                   br_en;
        logic [WB_DATA_MAX-1:0] u_imm;
        logic [WB_DATA_MAX-1:0] pc;
        logic [WB_DATA_MAX-1:0] addr;
    } wb_pkt_t;

    function automatic logic is_load(input wb_sel_e sel);
        return sel inside {LB, LBU, LH, LHU, LW, LWU, LD};
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load lane extraction: picks byte/half/word/dword at the address offset,
// extends it, and flags accesses that are not naturally aligned.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wb_sel_e                   sel,
    input  logic [$clog2(XLEN/8)-1:0] offset,
    input  logic [XLEN-1:0]           rdata,
    output logic [XLEN-1:0]           data,
    output logic                      misalign
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        data     = '0;
        misalign = 1'b0;
        unique case (sel)
            LB:  data = XLEN'($signed(shifted[7:0]));
            LBU: data = XLEN'(shifted[7:0]);
            LH: begin
                data     = XLEN'($signed(shifted[15:0]));
                misalign = offset[0];
            end
            LHU: begin
                data     = XLEN'(shifted[15:0]);
                misalign = offset[0];
            end
            LW: begin
                data     = XLEN'($signed(shifted[31:0]));
                misalign = |offset[1:0];
            end
            LWU: begin
                data     = XLEN'(shifted[31:0]);
                misalign = |offset[1:0];
            end
            LD: begin
                data     = shifted;
                misalign = |offset;
            end
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/wb_load_commit.sv
// Write-back/commit stage: holds one MEM/WB packet, waits for the dmem response on loads,
// drives the regfile write port and counts retired packets.
module wb_load_commit
    import wb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_valid_i,
    output logic                  wb_ready_o,
    input  wb_pkt_t               wb_pkt_i,
    input  logic                  dmem_resp_i,
    input  logic [XLEN-1:0]       dmem_rdata_i,
    input  logic                  flush_i,
    output logic                  rd_we_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic [XLEN-1:0]       rd_wdata_o,
    output logic                  commit_o,
    output logic                  misalign_o,
    output logic [CNT_W-1:0]      instret_o
);

    localparam int OFF_W = $clog2(XLEN/8);

    wb_state_e        state_q;
    wb_pkt_t          hold_q;
    logic [CNT_W-1:0] instret_q;

    logic            held;
    logic            hold_ld;
    logic            commit;
    logic            ready;
    logic            accept;
    logic [XLEN-1:0] ld_data;
    logic            ld_misalign;
    logic [XLEN-1:0] wdata;
    logic            we;
    logic            unused_pkt_bits;

    assign held    = (state_q == HELD);
    assign hold_ld = is_load(hold_q.sel);
    assign commit  = held & (~hold_ld | dmem_resp_i);
    assign ready   = (state_q == EMPTY) | (held & commit & ~flush_i);
    assign accept  = wb_valid_i & ready;

    wb_load_align #(.XLEN(XLEN)) u_align (
        .sel      (hold_q.sel),
        .offset   (hold_q.addr[OFF_W-1:0]),
        .rdata    (dmem_rdata_i),
        .data     (ld_data),
        .misalign (ld_misalign)
    );

    always_comb begin
        wdata = '0;
        unique case (hold_q.sel)
            ALU:     wdata = hold_q.alu_out[XLEN-1:0];
            BR_EN:   wdata = XLEN'(hold_q.br_en);
            U_IMM:   wdata = hold_q.u_imm[XLEN-1:0];
            PC4:     wdata = hold_q.pc[XLEN-1:0] + XLEN'(4);
            default: wdata = ld_data;
        endcase
    end

    assign misalign_o = commit & hold_ld & ld_misalign;
    assign we         = commit & hold_q.load_regfile & (hold_q.rd[REG_ADDR_W-1:0] != '0) & ~misalign_o;
    assign rd_we_o    = we;
    assign rd_addr_o  = we ? hold_q.rd[REG_ADDR_W-1:0] : '0;
    assign rd_wdata_o = we ? wdata : '0;
    assign commit_o   = commit;
    assign wb_ready_o = ready;
    assign instret_o  = instret_q;

    // Upper packet bits are dead in narrow configurations.
    assign unused_pkt_bits = ^{hold_q.rd, hold_q.alu_out, hold_q.u_imm, hold_q.pc, hold_q.addr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            hold_q    <= '0;
            instret_q <= '0;
        end else begin
            if (commit) instret_q <= instret_q + CNT_W'(1);
            unique case (state_q)
                EMPTY: begin
                    if (wb_valid_i) begin
                        state_q <= HELD;
                        hold_q  <= wb_pkt_i;
                    end
                end
                HELD: begin
                    if (commit) begin
                        if (accept) hold_q <= wb_pkt_i;
                        else        state_q <= EMPTY;
                    end else if (flush_i) begin
                        // A flushed load still has a response in flight that must be swallowed.
                        state_q <= hold_ld ? DRAIN : EMPTY;
                    end
                end
                DRAIN: begin
                    if (dmem_resp_i) state_q <= EMPTY;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    a_no_stray_resp: assert property (@(posedge clk) disable iff (!rst_n)
        !(dmem_resp_i && ((state_q == EMPTY) || (held && !hold_ld))));

endmodule

// File: tb/tb_wb_load_commit.sv
// Directed bench for wb_load_commit: XLEN=32 and XLEN=64 instances driven by one linear sequence.
module tb_wb_load_commit;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_pkt_t pkt;

    logic        v32, r32, f32, rdy32, we32, cm32, mis32;
    logic [31:0] rdata32, wd32;
    logic [4:0]  ad32;
    logic [63:0] ir32;

    logic        v64, r64, f64, rdy64, we64, cm64, mis64;
    logic [63:0] rdata64, wd64;
    logic [4:0]  ad64;
    logic [63:0] ir64;

    int passes = 0;
    int total  = 0;

    wb_load_commit #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(64)) u32 (
        .clk(clk), .rst_n(rst_n), .wb_valid_i(v32), .wb_ready_o(rdy32), .wb_pkt_i(pkt),
        .dmem_resp_i(r32), .dmem_rdata_i(rdata32), .flush_i(f32), .rd_we_o(we32),
        .rd_addr_o(ad32), .rd_wdata_o(wd32), .commit_o(cm32), .misalign_o(mis32),
        .instret_o(ir32)
    );

    wb_load_commit #(.XLEN(64), .REG_ADDR_W(5), .CNT_W(64)) u64 (
        .clk(clk), .rst_n(rst_n), .wb_valid_i(v64), .wb_ready_o(rdy64), .wb_pkt_i(pkt),
        .dmem_resp_i(r64), .dmem_rdata_i(rdata64), .flush_i(f64), .rd_we_o(we64),
        .rd_addr_o(ad64), .rd_wdata_o(wd64), .commit_o(cm64), .misalign_o(mis64),
        .instret_o(ir64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic wb_pkt_t mk(input wb_sel_e sel, input logic [7:0] rd,
                                   input logic [63:0] val, input logic [63:0] addr);
        wb_pkt_t p;
        p              = '0;
        p.rd           = rd;
        p.load_regfile = 1'b1;
        p.sel          = sel;
        p.alu_out      = val;
        p.br_en        = val[0];
        p.u_imm        = val;
        p.pc           = val;
        p.addr         = addr;
        return p;
    endfunction

    logic [31:0] pcs [4] = '{32'h100, 32'h104, 32'h108, 32'hFFFF_FFFC};
    logic [31:0] pce [4] = '{32'h104, 32'h108, 32'h10C, 32'h0};

    initial begin
        rst_n = 1'b0;
        v32 = 0; r32 = 0; f32 = 0; rdata32 = '0;
        v64 = 0; r64 = 0; f64 = 0; rdata64 = '0;
        pkt = '0;
        #2;
        check("rst_ready32", rdy32, 1);
        check("rst_commit32", cm32, 0);
        check("rst_we32", we32, 0);
        check("rst_instret32", ir32, 0);
        check("rst_ready64", rdy64, 1);
        @(negedge clk);
        rst_n = 1'b1;
        nxt();

        // ALU packet retires the cycle after acceptance
        pkt = mk(ALU, 8'd5, 64'h1234, 64'h0);
        v32 = 1;
        #1 check("alu_ready_empty", rdy32, 1);
        nxt(); v32 = 0;
        #1;
        check("alu_commit", cm32, 1);
        check("alu_we", we32, 1);
        check("alu_addr", ad32, 5);
        check("alu_wdata", wd32, 32'h1234);
        check("alu_instret_before", ir32, 0);
        nxt(); #1;
        check("alu_commit_after", cm32, 0);
        check("alu_instret_after", ir32, 1);

        // LB with 3 stalled cycles, LBU accepted in the response cycle
        pkt = mk(LB, 8'd7, 64'h0, 64'h1003);
        v32 = 1;
        nxt(); v32 = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lb_stall_ready", rdy32, 0);
            check("lb_stall_commit", cm32, 0);
            nxt();
        end
        r32 = 1; rdata32 = 32'h80FF_0000;
        pkt = mk(LBU, 8'd7, 64'h0, 64'h1003);
        v32 = 1;
        #1;
        check("lb_commit", cm32, 1);
        check("lb_we", we32, 1);
        check("lb_addr", ad32, 7);
        check("lb_wdata", wd32, 32'hFFFF_FF80);
        check("lb_ready_resp", rdy32, 1);
        nxt(); r32 = 0; v32 = 0;
        #1;
        check("lbu_held_ready", rdy32, 0);
        check("lb_instret", ir32, 2);
        nxt(); r32 = 1;
        #1;
        check("lbu_commit", cm32, 1);
        check("lbu_wdata", wd32, 32'h0000_0080);
        nxt(); r32 = 0;
        #1 check("lbu_instret", ir32, 3);

        // Misaligned LH, then LW to x0
        pkt = mk(LH, 8'd3, 64'h0, 64'h2001);
        v32 = 1;
        nxt(); v32 = 0; r32 = 1; rdata32 = 32'h1234_5678;
        #1;
        check("lh_mis_commit", cm32, 1);
        check("lh_mis_flag", mis32, 1);
        check("lh_mis_we", we32, 0);
        check("lh_mis_wdata", wd32, 0);
        nxt(); r32 = 0;
        pkt = mk(LW, 8'd0, 64'h0, 64'h2000);
        v32 = 1;
        #1 check("lh_mis_instret", ir32, 4);
        nxt(); v32 = 0; r32 = 1;
        #1;
        check("lw_x0_commit", cm32, 1);
        check("lw_x0_we", we32, 0);
        check("lw_x0_mis", mis32, 0);
        check("lw_x0_addr", ad32, 0);
        nxt(); r32 = 0;
        #1 check("lw_x0_instret", ir32, 5);

        // Flush a held load; response arrives two cycles later while draining
        pkt = mk(LW, 8'd4, 64'h0, 64'h2000);
        v32 = 1;
        nxt(); v32 = 0; f32 = 1;
        #1;
        check("flush_commit", cm32, 0);
        check("flush_ready", rdy32, 0);
        nxt(); f32 = 0;
        #1;
        check("drain_ready", rdy32, 0);
        check("drain_commit", cm32, 0);
        nxt(); r32 = 1; rdata32 = 32'hDEAD_BEEF;
        #1;
        check("drain_resp_commit", cm32, 0);
        check("drain_resp_we", we32, 0);
        check("drain_resp_ready", rdy32, 0);
        nxt(); r32 = 0;
        #1;
        check("drain_done_ready", rdy32, 1);
        check("drain_instret", ir32, 5);

        // Flush coinciding with a commit does not kill it
        pkt = mk(ALU, 8'd9, 64'hABCD, 64'h0);
        v32 = 1;
        nxt(); v32 = 0; f32 = 1;
        #1;
        check("flushc_commit", cm32, 1);
        check("flushc_we", we32, 1);
        check("flushc_wdata", wd32, 32'hABCD);
        check("flushc_ready", rdy32, 0);
        nxt(); f32 = 0;
        #1;
        check("flushc_instret", ir32, 6);
        check("flushc_ready_after", rdy32, 1);

        // Back-to-back PC4 stream, last one wraps
        pkt = mk(PC4, 8'd1, 64'(pcs[0]), 64'h0);
        v32 = 1;
        for (int i = 1; i <= 4; i++) begin
            nxt();
            if (i < 4) pkt = mk(PC4, 8'(i + 1), 64'(pcs[i]), 64'h0);
            else       v32 = 0;
            #1;
            check("pc4_commit", cm32, 1);
            check("pc4_wdata", wd32, pce[i-1]);
            check("pc4_ready", rdy32, 1);
        end
        nxt(); #1;
        check("pc4_instret", ir32, 10);
        check("pc4_idle_commit", cm32, 0);

        // BR_EN then U_IMM
        pkt = mk(BR_EN, 8'd2, 64'h1, 64'h0);
        v32 = 1;
        nxt(); pkt = mk(U_IMM, 8'd3, 64'h1234_5000, 64'h0);
        #1 check("br_en_wdata", wd32, 1);
        nxt(); v32 = 0;
        #1 check("u_imm_wdata", wd32, 32'h1234_5000);
        nxt(); #1;
        check("br_u_instret", ir32, 12);

        // XLEN=64 loads
        pkt = mk(LD, 8'd2, 64'h0, 64'h3000);
        v64 = 1;
        nxt(); v64 = 0; r64 = 1; rdata64 = 64'h8000_0000_0000_0001;
        #1;
        check("ld_wdata", wd64, 64'h8000_0000_0000_0001);
        check("ld_we", we64, 1);
        check("ld_mis", mis64, 0);
        nxt(); r64 = 0;
        pkt = mk(LWU, 8'd2, 64'h0, 64'h3004);
        v64 = 1;
        nxt(); v64 = 0; r64 = 1; rdata64 = 64'h8000_0000_1234_5678;
        #1 check("lwu_wdata", wd64, 64'h0000_0000_8000_0000);
        nxt(); r64 = 0;
        pkt = mk(LW, 8'd2, 64'h0, 64'h3004);
        v64 = 1;
        nxt(); v64 = 0; r64 = 1;
        #1 check("lw64_wdata", wd64, 64'hFFFF_FFFF_8000_0000);
        nxt(); r64 = 0;
        #1 check("x64_instret", ir64, 3);

        // Counter wrap
        force u64.instret_q = {64{1'b1}};
        #1 release u64.instret_q;
        #1 check("wrap_preload", ir64, {64{1'b1}});
        pkt = mk(ALU, 8'd1, 64'h5, 64'h0);
        v64 = 1;
        nxt(); v64 = 0;
        #1 check("wrap_commit", cm64, 1);
        nxt(); #1;
        check("wrap_instret", ir64, 0);

        // Asynchronous reset during a load response
        pkt = mk(LW, 8'd6, 64'h0, 64'h2000);
        v32 = 1;
        nxt(); v32 = 0; r32 = 1; rdata32 = 32'h55;
        #1;
        check("prerst_commit", cm32, 1);
        check("prerst_we", we32, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_commit", cm32, 0);
        check("midrst_we", we32, 0);
        check("midrst_wdata", wd32, 0);
        check("midrst_addr", ad32, 0);
        check("midrst_instret", ir32, 0);
        check("midrst_ready", rdy32, 1);
        r32 = 0;
        nxt();
        rst_n = 1'b1;
        nxt();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
